// File: rtl/dsc_pkg.sv
// Shared widths for the deterministic stochastic-computing multiplier.
package dsc_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int NUM_INPUTS = 2;
  localparam int PROD_WIDTH = NUM_INPUTS * DATA_WIDTH;
  localparam int WXIP1      = PROD_WIDTH + 1;

endpackage

// File: rtl/dsc_counter.sv
// Wrapping up-counter with a programmable stride and a registered wrap pulse.
module dsc_counter
  import dsc_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STRIDE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] countval,
  output logic             overflow
);

  // One extra bit so the carry out of the add marks the wrap.
  logic [WIDTH:0] sum;

  assign sum = {1'b0, countval} + (WIDTH + 1)'(STRIDE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      countval <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= en & sum[WIDTH];
      if (en) countval <= sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/dsc_core.sv
// DSC multiplier: phase counter fields drive unary streams, a ones counter on
// their AND accumulates the product of all operands.
module dsc_core
  import dsc_pkg::*;
#(
  parameter int DATA_WIDTH = dsc_pkg::DATA_WIDTH,
  parameter int NUM_INPUTS = dsc_pkg::NUM_INPUTS
) (
  input  logic                             gclk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [DATA_WIDTH-1:0]            bin_data_in [NUM_INPUTS],
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] bin_data_out,
  output logic                             op_finished
);

  localparam int PW = NUM_INPUTS * DATA_WIDTH;

  logic [PW-1:0] phase;
  logic [PW-1:0] acc;
  logic          phase_wrap;
  logic          fin_q;
  logic          advance;
  logic          hit;
  logic          acc_unused_ovf;

  // The wrap pulse counts as finished on its own cycle, so P and acc freeze
  // immediately after the wrapping edge rather than one edge later.
  assign op_finished = fin_q | phase_wrap;
  assign advance     = en & ~op_finished;

  always_comb begin
    hit = 1'b1;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (phase[i*DATA_WIDTH +: DATA_WIDTH] >= bin_data_in[i]) hit = 1'b0;
    end
  end

  dsc_counter #(.WIDTH(PW), .STRIDE(1)) u_phase (
    .clk      (gclk),
    .rst      (rst),
    .en       (advance),
    .countval (phase),
    .overflow (phase_wrap)
  );

  // The product never exceeds the output width, so this wrap is unused.
  dsc_counter #(.WIDTH(PW), .STRIDE(1)) u_acc (
    .clk      (gclk),
    .rst      (rst),
    .en       (advance & hit),
    .countval (acc),
    .overflow (acc_unused_ovf)
  );

  always_ff @(posedge gclk) begin
    if (!rst)            fin_q <= 1'b0;
    else if (phase_wrap) fin_q <= 1'b1;
  end

  assign bin_data_out = acc;

endmodule

// File: tb/tb_dsc_core.sv
// Scoreboard bench for dsc_core: N=2/DW=4 directed+random and N=3/DW=4 random.
module tb_dsc_core;
  import dsc_pkg::*;

  localparam int FULL_A = 256;
  localparam int FULL_B = 4096;

  typedef struct {
    string  name;
    int     dut;
    longint exp_out;
    bit     exp_fin;
  } snap_t;

  typedef struct {
    longint exp_out;
    int     exp_k;
  } fin_t;

  logic              gclk;
  logic              rst_a, rst_b, rst_tb;
  logic              en_a, en_b;
  logic [3:0]        x_a [2];
  logic [3:0]        x_b [3];
  logic [7:0]        out_a;
  logic [11:0]       out_b;
  logic              fin_a, fin_b;
  logic [WXIP1-1:0]  cyc;
  logic              cyc_unused_ovf;

  int     xa [3];
  int     xb [3];
  int     k_a, k_b;
  int     checks, passed;
  bit     fin_a_prev, fin_b_prev;
  snap_t  q_snap [$];
  fin_t   q_fin_a [$];
  fin_t   q_fin_b [$];

  dsc_core #(.DATA_WIDTH(4), .NUM_INPUTS(2)) u_dut_a (
    .gclk         (gclk),
    .rst          (rst_a),
    .en           (en_a),
    .bin_data_in  (x_a),
    .bin_data_out (out_a),
    .op_finished  (fin_a)
  );

  dsc_core #(.DATA_WIDTH(4), .NUM_INPUTS(3)) u_dut_b (
    .gclk         (gclk),
    .rst          (rst_b),
    .en           (en_b),
    .bin_data_in  (x_b),
    .bin_data_out (out_b),
    .op_finished  (fin_b)
  );

  dsc_counter #(.WIDTH(WXIP1), .STRIDE(1)) u_cyc (
    .clk      (gclk),
    .rst      (rst_tb),
    .en       (1'b1),
    .countval (cyc),
    .overflow (cyc_unused_ovf)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  // Reference: count phase values p in [0,k) whose base-2^dw digits are all below the operands.
  function automatic longint partial(int xs[3], int n, int dw, int k);
    longint cnt;
    int     base;
    int     v;
    bit     ok;
    cnt  = 0;
    base = 1 << dw;
    for (int p = 0; p < k; p++) begin
      ok = 1'b1;
      v  = p;
      for (int i = 0; i < n; i++) begin
        if ((v % base) >= xs[i]) ok = 1'b0;
        v = v / base;
      end
      if (ok) cnt++;
    end
    return cnt;
  endfunction

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic set_a(int a0, int a1);
    xa[0] = a0; xa[1] = a1; xa[2] = 0;
    x_a[0] = 4'(a0); x_a[1] = 4'(a1);
  endtask

  task automatic set_b(int b0, int b1, int b2);
    xb[0] = b0; xb[1] = b1; xb[2] = b2;
    x_b[0] = 4'(b0); x_b[1] = 4'(b1); x_b[2] = 4'(b2);
  endtask

  // Reset is applied with en high to exercise reset priority.
  task automatic reset_a();
    rst_a = 1'b0; en_a = 1'b1;
    @(posedge gclk); #2;
    rst_a = 1'b1; en_a = 1'b0; k_a = 0;
  endtask

  task automatic reset_b();
    rst_b = 1'b0; en_b = 1'b1;
    @(posedge gclk); #2;
    rst_b = 1'b1; en_b = 1'b0; k_b = 0;
  endtask

  task automatic step_a(int n, bit e);
    en_a = e;
    repeat (n) begin
      @(posedge gclk); #2;
      if (e) k_a++;
    end
    en_a = 1'b0;
  endtask

  task automatic step_b(int n, bit e);
    en_b = e;
    repeat (n) begin
      @(posedge gclk); #2;
      if (e) k_b++;
    end
    en_b = 1'b0;
  endtask

  task automatic snap_a(string name);
    int k;
    k = (k_a < FULL_A) ? k_a : FULL_A;
    q_snap.push_back('{name, 0, partial(xa, 2, 4, k), k_a >= FULL_A});
  endtask

  task automatic snap_b(string name);
    int k;
    k = (k_b < FULL_B) ? k_b : FULL_B;
    q_snap.push_back('{name, 1, partial(xb, 3, 4, k), k_b >= FULL_B});
  endtask

  task automatic expect_final_a();
    q_fin_a.push_back('{longint'(xa[0] * xa[1]), FULL_A});
  endtask

  task automatic expect_final_b();
    q_fin_b.push_back('{longint'(xb[0] * xb[1] * xb[2]), FULL_B});
  endtask

  // Monitor: drains snapshot requests and checks each op_finished rise against the final queue.
  always @(negedge gclk) begin
    snap_t s;
    fin_t  f;
    while (q_snap.size() > 0) begin
      s = q_snap.pop_front();
      if (s.dut == 0) begin
        check({s.name, "_out"}, out_a, s.exp_out);
        check({s.name, "_fin"}, fin_a, s.exp_fin);
      end else begin
        check({s.name, "_out"}, out_b, s.exp_out);
        check({s.name, "_fin"}, fin_b, s.exp_fin);
      end
    end
    if (fin_a && !fin_a_prev) begin
      if (q_fin_a.size() == 0) check("fin_a_unexpected", 1, 0);
      else begin
        f = q_fin_a.pop_front();
        check("final_a_out", out_a, f.exp_out);
        check("final_a_edges", k_a, f.exp_k);
      end
    end
    if (fin_b && !fin_b_prev) begin
      if (q_fin_b.size() == 0) check("fin_b_unexpected", 1, 0);
      else begin
        f = q_fin_b.pop_front();
        check("final_b_out", out_b, f.exp_out);
        check("final_b_edges", k_b, f.exp_k);
      end
    end
    fin_a_prev = fin_a;
    fin_b_prev = fin_b;
  end

  always @(negedge gclk) begin
    if (rst_tb && int'(cyc) > 40000) begin
      $display("FAIL watchdog: cycles %0d exceeded limit 40000", cyc);
      $fatal(1, "watchdog expired");
    end
  end

  initial begin
    int r, kr;
    checks = 0; passed = 0; k_a = 0; k_b = 0;
    fin_a_prev = 1'b0; fin_b_prev = 1'b0;
    rst_a = 1'b0; rst_b = 1'b0; rst_tb = 1'b0;
    en_a = 1'b0; en_b = 1'b0;
    set_a(0, 0); set_b(0, 0, 0);
    repeat (3) @(posedge gclk);
    #2;
    rst_a = 1'b1; rst_b = 1'b1; rst_tb = 1'b1;
    snap_a("reset_state_a");
    snap_b("reset_state_b");

    set_a(3, 5); reset_a(); expect_final_a();
    step_a(FULL_A, 1'b1); snap_a("x3x5_done");
    step_a(10, 1'b1);     snap_a("x3x5_frozen");

    set_a(15, 15); reset_a(); expect_final_a();
    step_a(FULL_A, 1'b1); snap_a("x15x15_done");

    set_a(0, 9); reset_a(); expect_final_a();
    step_a(FULL_A, 1'b1); snap_a("x0x9_done");

    set_a(15, 15); reset_a();
    step_a(128, 1'b1); snap_a("x15x15_early128");

    set_a(7, 6); reset_a(); expect_final_a();
    step_a(100, 1'b1); snap_a("x7x6_pre_gap");
    step_a(50, 1'b0);  snap_a("x7x6_gap_hold");
    step_a(156, 1'b1); snap_a("x7x6_done");

    set_a(2, 2); reset_a();
    step_a(100, 1'b1); snap_a("x2x2_cycle100");
    reset_a();         snap_a("x2x2_after_reset");
    expect_final_a();
    step_a(FULL_A, 1'b1); snap_a("x2x2_done");

    for (int t = 0; t < 5; t++) begin
      set_a($urandom_range(0, 15), $urandom_range(0, 15));
      reset_a();
      kr = $urandom_range(1, 300);
      if (kr >= FULL_A) expect_final_a();
      step_a(kr, 1'b1);
      snap_a($sformatf("rand_a%0d_k%0d", t, kr));
    end

    for (int t = 0; t < 3; t++) begin
      set_b($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(1, 15));
      reset_b(); expect_final_b();
      r = $urandom_range(1, FULL_B - 1);
      step_b(r, 1'b1); snap_b($sformatf("rand_b%0d_mid", t));
      step_b(FULL_B - r, 1'b1); snap_b($sformatf("rand_b%0d_done", t));
      step_b(20, 1'b1); snap_b($sformatf("rand_b%0d_frozen", t));
    end

    @(negedge gclk);
    @(negedge gclk);
    check("final_a_pending", q_fin_a.size(), 0);
    check("final_b_pending", q_fin_b.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
